// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requesters onto a single shared memory port with
// round-robin priority, one outstanding transaction, and fetch-kill handling.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  input  logic                if_kill_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_e;
  typedef enum logic {OWN_IF, OWN_D} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              drop_q, drop_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic fetch_ok;
  logic pick_data;
  logic kill_own;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_D;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      drop_q  <= drop_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    drop_d      = drop_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    mem_req_o   = 1'b0;
    // A killed fetch in IDLE is not a candidate, so data may win that cycle.
    fetch_ok    = if_req_i & ~if_kill_i;
    pick_data   = d_req_i & (~fetch_ok | (last_q == OWN_IF));
    kill_own    = (owner_q == OWN_IF) & if_kill_i;

    unique case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (fetch_ok || d_req_i) begin
          state_d = ISSUE;
          if (pick_data) begin
            owner_d = OWN_D;
            we_d    = d_we_i;
            be_d    = d_be_i;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
          end else begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            be_d    = '1;
            addr_d  = if_addr_i;
            wdata_d = '0;
          end
        end
      end
      ISSUE: begin
        mem_req_o = 1'b1;
        if (kill_own && !mem_gnt_i) begin
          state_d = IDLE;
        end else if (mem_gnt_i) begin
          if (owner_q == OWN_D) d_gnt_o = 1'b1;
          else                  if_gnt_o = 1'b1;
          last_d  = owner_q;
          state_d = WAIT_RESP;
          if (kill_own) drop_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (kill_own) drop_d = 1'b1;
        if (mem_rvalid_i) begin
          if (owner_q == OWN_D) d_rvalid_o = 1'b1;
          else                  if_rvalid_o = ~(drop_q | kill_own);
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_we_o    = we_q;
  assign mem_be_o    = be_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address buses.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data buses; byte-enable width DATA_W/8.
REQ-003 SHALL have ports, one per line: name  direction  width  meaning:
 clk_i  in  1  single clock; all state on rising edge
 reset_i  in  1  asynchronous, active-low reset
 if_req_i  in  1  fetch read request; held with stable if_addr_i until if_gnt_o
 if_addr_i  in  ADDR_W  fetch address
 if_kill_i  in  1  fetch redirect; abandon outstanding fetch
 if_gnt_o  out  1  one-cycle pulse: fetch accepted by memory
 if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid
 if_rdata_o  out  DATA_W  fetch read data
 d_req_i  in  1  data request; held with stable fields until d_gnt_o
 d_we_i  in  1  1 = store, 0 = load
 d_be_i  in  DATA_W/8  store byte enables
 d_addr_i  in  ADDR_W  data address
 d_wdata_i  in  DATA_W  store data
 d_gnt_o  out  1  one-cycle pulse: data request accepted
 d_rvalid_o  out  1  one-cycle pulse: load data / store completion
 d_rdata_o  out  DATA_W  load data
 mem_req_o  out  1  shared memory request
 mem_we_o  out  1  shared memory write enable
 mem_be_o  out  DATA_W/8  shared memory byte enables
 mem_addr_o  out  ADDR_W  shared memory address
 mem_wdata_o  out  DATA_W  shared memory write data
 mem_gnt_i  in  1  memory accepts request this cycle
 mem_rvalid_i  in  1  memory response valid (reads and writes)
 mem_rdata_i  in  DATA_W  memory read data
 busy_o  out  1  state != IDLE

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, WAIT_RESP; at most one transaction outstanding.
REQ-005 IDLE: if any request pending, SHALL latch winner's fields and owner, go ISSUE next cycle; else stay.
REQ-006 Arbitration on conflict SHALL be round-robin via last_owner register; only-one request -> that requester wins.
REQ-007 ISSUE: mem_req_o=1 with latched fields; fields SHALL stay stable until mem_gnt_i.
REQ-008 ISSUE with mem_gnt_i=1: SHALL pulse owner's gnt_o same cycle (combinational), update last_owner, go WAIT_RESP.
REQ-009 WAIT_RESP with mem_rvalid_i=1: SHALL pulse owner's rvalid_o same cycle, rdata_o = mem_rdata_i, go IDLE.
REQ-010 Minimum latency: req in IDLE cycle N -> mem_req_o cycle N+1 -> gnt_o cycle N+1 if mem_gnt_i -> rvalid_o cycle N+2 if mem_rvalid_i.
REQ-011 Non-owner gnt_o/rvalid_o SHALL be 0; fetch fields SHALL drive mem_we_o=0, mem_be_o=all-ones, mem_wdata_o=0.
REQ-012 mem_rvalid_i outside WAIT_RESP SHALL be ignored; mem_gnt_i outside ISSUE ignored.
REQ-013 if_kill_i in ISSUE, owner fetch, mem_gnt_i=0: SHALL drop mem_req_o next cycle, go IDLE, no if_gnt_o.
REQ-014 if_kill_i in ISSUE with mem_gnt_i=1, or in WAIT_RESP, owner fetch: SHALL set drop flag; response consumed, if_rvalid_o suppressed, flag cleared on return to IDLE.
REQ-015 if_kill_i SHALL not affect data transactions; in IDLE, kill cancels a same-cycle fetch win (data may win instead).
REQ-016 Request arriving in IDLE same cycle as WAIT_RESP completion SHALL be arbitrated the following cycle (no back-to-back bypass).
REQ-017 if_rdata_o/d_rdata_o SHALL reflect mem_rdata_i unconditionally; valid only with rvalid.

Reset
REQ-018 reset_i low SHALL asynchronously force IDLE, last_owner=data (first conflict goes to fetch), drop flag=0, latched fields=0.
REQ-019 During/after reset all outputs SHALL be 0 except data buses (0); reset mid-transaction SHALL abandon it silently, no gnt/rvalid pulses.

Verification
REQ-020 Bench SHALL cover:
 - Lone load addr 0x100, mem_gnt_i at 1st ISSUE cycle, rvalid 1 later, rdata 0xDEADBEEF -> d_gnt_o cycle 1, d_rvalid_o cycle 2, d_rdata_o 0xDEADBEEF.
 - Fetch and store simultaneous from reset -> fetch first, store second; store mem_be_o=4'b0011, mem_wdata_o=0x1234 held stable through 3 gnt-wait cycles.
 - Continuous if_req_i and d_req_i for 6 transactions -> owners alternate I,D,I,D,I,D.
 - if_kill_i in WAIT_RESP for fetch 0x200 -> mem_rvalid_i consumed, if_rvalid_o stays 0, busy_o low next cycle.
 - if_kill_i in ISSUE, mem_gnt_i=0 -> mem_req_o low next cycle, no if_gnt_o.
 - reset_i low during WAIT_RESP -> busy_o=0, mem_req_o=0 immediately; later mem_rvalid_i produces no rvalid pulse.
